// File: rtl/game_fsm_multi.sv
// rtl/game_fsm_multi.sv - sprite priority select plus lives/level/sound game state machine
//
// Ports:
//   clk, resetN          clock; asynchronous active-low reset
//   start                pulse: begin or restart a game
//   frame_start          pulse at the start of each VGA frame
//   player_draw_req      player pixel active
//   obj_draw_req         per-object pixel active
//   select_mux           0 = background, i+1 = object i, NUM_OBJ+1 = player (combinational)
//   lives, level         remaining lives, current level
//   win, lose, game_over high while in WIN / HIT / GAMEOVER
//   player_reset         one-cycle pulse on every entry into PLAY
//   sound_freq           tone code, 0 when silent
//   enable_sound         tone on

module game_fsm_multi #(
  parameter int                 NUM_OBJ     = 8,
  parameter int                 SEL_W       = 8,
  parameter int                 PLAYER_PRIO = 2,
  parameter logic [NUM_OBJ-1:0] LETHAL_MASK = 8'b0000_0011,
  parameter logic [NUM_OBJ-1:0] GOAL_MASK   = 8'b1000_0000,
  parameter int                 LIVES       = 3,
  parameter int                 LVL_W       = 4,
  parameter int                 SOUND_CYC   = 25_000_000,
  parameter logic [9:0]         HIT_FREQ    = 10'd682,
  parameter logic [9:0]         WIN_FREQ    = 10'd341,
  parameter logic [9:0]         OVER_FREQ   = 10'd1002,
  localparam int                LIV_W       = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic               frame_start,
  input  logic               player_draw_req,
  input  logic [NUM_OBJ-1:0] obj_draw_req,
  output logic [SEL_W-1:0]   select_mux,
  output logic [LIV_W-1:0]   lives,
  output logic [LVL_W-1:0]   level,
  output logic               win,
  output logic               lose,
  output logic               game_over,
  output logic               player_reset,
  output logic [9:0]         sound_freq,
  output logic               enable_sound
);

  localparam int               TMR_W      = $clog2(SOUND_CYC);
  localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(SOUND_CYC - 1);
  localparam logic [LIV_W-1:0] LIVES_INIT = LIV_W'(LIVES);
  localparam logic [LVL_W-1:0] LVL_MAX    = '1;

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_HIT, S_WIN, S_OVER} state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             hit, goal, hit_n, goal_n;
  logic [LIV_W-1:0] lives_n;
  logic [LVL_W-1:0] level_n;
  logic             run_n;
  logic [9:0]       freq_n;
  logic             hit_pix, goal_pix;

  assign hit_pix  = player_draw_req & |(obj_draw_req & LETHAL_MASK);
  assign goal_pix = player_draw_req & |(obj_draw_req & GOAL_MASK);

  // Later assignments win: low-priority objects first, then the player,
  // then the objects that draw over the player.
  always_comb begin
    select_mux = '0;
    for (int i = NUM_OBJ - 1; i >= PLAYER_PRIO; i--)
      if (obj_draw_req[i]) select_mux = SEL_W'(i + 1);
    if (player_draw_req) select_mux = SEL_W'(NUM_OBJ + 1);
    for (int i = PLAYER_PRIO - 1; i >= 0; i--)
      if (obj_draw_req[i]) select_mux = SEL_W'(i + 1);
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    lives_n = lives;
    level_n = level;
    hit_n   = 1'b0;
    goal_n  = 1'b0;
    run_n   = enable_sound;
    freq_n  = '0;
    if (timer != '0) timer_n = timer - 1'b1;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_PLAY;
          lives_n = LIVES_INIT;
          level_n = '0;
        end
      end
      S_PLAY: begin
        // Decisions use the flags of the frame just ended; a collision in the
        // frame_start cycle seeds the flags of the new frame.
        hit_n  = (frame_start ? 1'b0 : hit)  | hit_pix;
        goal_n = (frame_start ? 1'b0 : goal) | goal_pix;
        if (frame_start && hit) begin
          lives_n = lives - 1'b1;
          state_n = (lives_n == '0) ? S_OVER : S_HIT;
        end else if (frame_start && goal) begin
          state_n = S_WIN;
        end
      end
      S_HIT: begin
        if (timer == '0) state_n = S_PLAY;
      end
      S_WIN: begin
        if (timer == '0) begin
          state_n = S_PLAY;
          if (level != LVL_MAX) level_n = level + 1'b1;
        end
      end
      S_OVER: begin
        // Tone ends after its last timed cycle; the state itself waits for start.
        if (timer == '0) run_n = 1'b0;
        if (start) begin
          state_n = S_PLAY;
          lives_n = LIVES_INIT;
          level_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != state) begin
      timer_n = TMR_LOAD;
      run_n   = (state_n == S_HIT) || (state_n == S_WIN) || (state_n == S_OVER);
    end
    if (state_n != S_PLAY) begin
      hit_n  = 1'b0;
      goal_n = 1'b0;
    end

    if (run_n) begin
      case (state_n)
        S_HIT:   freq_n = HIT_FREQ;
        S_WIN:   freq_n = WIN_FREQ;
        S_OVER:  freq_n = OVER_FREQ;
        default: freq_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= S_IDLE;
      timer        <= '0;
      hit          <= 1'b0;
      goal         <= 1'b0;
      lives        <= LIVES_INIT;
      level        <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      game_over    <= 1'b0;
      player_reset <= 1'b0;
      sound_freq   <= '0;
      enable_sound <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      hit          <= hit_n;
      goal         <= goal_n;
      lives        <= lives_n;
      level        <= level_n;
      win          <= (state_n == S_WIN);
      lose         <= (state_n == S_HIT);
      game_over    <= (state_n == S_OVER);
      player_reset <= (state_n == S_PLAY) && (state != S_PLAY);
      sound_freq   <= freq_n;
      enable_sound <= run_n;
    end
  end

endmodule
